// File: rtl/pwm_core.sv
// pwm_core -- two-channel edge-aligned PWM timer with shadowed configuration.
//
// A prescaler divides clk_psc_i; each prescaler tick advances an up-counter
// that wraps at the auto-reload value. Each channel asserts its reference
// while start <= count < end and drives a main and a complementary output.
// All period/compare/config values are double-buffered. The shadows load
// while the counter is disabled, and at every wrap, so a period always runs
// on one consistent set of values.
//
// Optional feature: define PWM_DEADTIME_EN to build per-channel dead-time
// insertion. Without it, the dtg_chX_i inputs are ignored.
//
// Ports
//   clk_psc_i                   single clock
//   rst_i                       synchronous active-high reset
//   cen_i                       counter enable
//   psc_preload_i               prescaler preload (tick every psc+1 clocks)
//   arr_preload_i               auto-reload preload (count 0..arr)
//   cmp_chX_start_i/_end_i      compare window, X = 1,2
//   cfg_chX_i                   [0]=enable, [1]=polarity (1=active-low),
//                               [2]=complementary enable, [7:3] ignored
//   dtg_chX_i                   dead time in clk_psc_i cycles
//   pwm_chX_o / pwm_chXn_o      registered main / complementary outputs
//   cnt_o                       current counter value
//   update_o                    one-cycle pulse while cnt_o=0 after a wrap

module pwm_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk_psc_i,
    input  logic             rst_i,
    input  logic             cen_i,
    input  logic [WIDTH-1:0] psc_preload_i,
    input  logic [WIDTH-1:0] arr_preload_i,
    input  logic [WIDTH-1:0] cmp_ch1_start_i,
    input  logic [WIDTH-1:0] cmp_ch1_end_i,
    input  logic [WIDTH-1:0] cmp_ch2_start_i,
    input  logic [WIDTH-1:0] cmp_ch2_end_i,
    input  logic [7:0]       cfg_ch1_i,
    input  logic [7:0]       cfg_ch2_i,
    input  logic [7:0]       dtg_ch1_i,
    input  logic [7:0]       dtg_ch2_i,
    output logic             pwm_ch1_o,
    output logic             pwm_ch1n_o,
    output logic             pwm_ch2_o,
    output logic             pwm_ch2n_o,
    output logic [WIDTH-1:0] cnt_o,
    output logic             update_o
);

    // Per-channel views of the inputs so the channel logic is written once.
    logic [WIDTH-1:0] start_in [2];
    logic [WIDTH-1:0] end_in   [2];
    logic [2:0]       cfg_in   [2];

    assign start_in[0] = cmp_ch1_start_i;
    assign start_in[1] = cmp_ch2_start_i;
    assign end_in[0]   = cmp_ch1_end_i;
    assign end_in[1]   = cmp_ch2_end_i;
    assign cfg_in[0]   = cfg_ch1_i[2:0];
    assign cfg_in[1]   = cfg_ch2_i[2:0];

    // Counter state
    logic [WIDTH-1:0] psc_cnt_q, psc_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             update_q, update_d;
    logic             tick, wrap, load;

    // Shadow registers
    logic [WIDTH-1:0] psc_q, psc_d;
    logic [WIDTH-1:0] arr_q, arr_d;
    logic [WIDTH-1:0] start_q [2];
    logic [WIDTH-1:0] start_d [2];
    logic [WIDTH-1:0] end_q   [2];
    logic [WIDTH-1:0] end_d   [2];
    logic [2:0]       cfg_q   [2];
    logic [2:0]       cfg_d   [2];

    // Channel datapath
    logic [1:0] ref_c;
    logic [1:0] ph_main;
    logic [1:0] ph_comp;
    logic [1:0] pol;
    logic [1:0] pwm_q, pwm_d;
    logic [1:0] pwmn_q, pwmn_d;

`ifdef PWM_DEADTIME_EN
    logic [7:0] dtg_in [2];
    logic [7:0] dtg_q  [2];
    logic [7:0] dtg_d  [2];
    logic [7:0] dt_q   [2];
    logic [7:0] dt_d   [2];
    logic [1:0] ref_prev_q, ref_prev_d;

    assign dtg_in[0] = dtg_ch1_i;
    assign dtg_in[1] = dtg_ch2_i;

    logic unused_bits;
    assign unused_bits = ^{cfg_ch1_i[7:3], cfg_ch2_i[7:3]};
`else
    logic unused_bits;
    assign unused_bits = ^{cfg_ch1_i[7:3], cfg_ch2_i[7:3], dtg_ch1_i, dtg_ch2_i};
`endif

    // Prescaler and period counter
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        psc_cnt_d = psc_cnt_q;
        cnt_d     = cnt_q;
        tick      = 1'b0;
        wrap      = 1'b0;
        if (cen_i) begin
            tick      = (psc_cnt_q == psc_q);
            psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
            if (tick) begin
                wrap  = (cnt_q == arr_q);
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
            end
        end else begin
            psc_cnt_d = '0;
            cnt_d     = '0;
        end
        // The flop delays the wrap by one edge, so the pulse lines up with cnt_o=0.
        update_d = wrap;
        load     = ~cen_i | wrap;
    end

    // Shadows follow the preloads while stopped and reload at each wrap.
    always_comb begin
        psc_d = load ? psc_preload_i : psc_q;
        arr_d = load ? arr_preload_i : arr_q;
        for (int i = 0; i < 2; i++) begin
            start_d[i] = load ? start_in[i] : start_q[i];
            end_d[i]   = load ? end_in[i]   : end_q[i];
            cfg_d[i]   = load ? cfg_in[i]   : cfg_q[i];
`ifdef PWM_DEADTIME_EN
            dtg_d[i]   = load ? dtg_in[i]   : dtg_q[i];
`endif
        end
    end

    // Channel reference, phases, dead-time gating and polarity
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            // An empty window (start >= end) can never satisfy both compares.
            ref_c[i]   = cfg_q[i][0] && (cnt_q >= start_q[i]) && (cnt_q < end_q[i]);
            ph_main[i] = ref_c[i];
            ph_comp[i] = cfg_q[i][0] && cfg_q[i][2] && !ref_c[i];
`ifdef PWM_DEADTIME_EN
            ref_prev_d[i] = cen_i & ref_c[i];
            if (!cen_i) begin
                dt_d[i] = '0;
            end else if (ref_c[i] != ref_prev_q[i]) begin
                dt_d[i] = dtg_q[i];
            end else if (dt_q[i] != '0) begin
                dt_d[i] = dt_q[i] - 8'd1;
            end else begin
                dt_d[i] = '0;
            end
            // Gate on the next counter value so the gap is exactly D cycles
            // long and D=0 adds no delay.
            if (dt_d[i] != '0) begin
                ph_main[i] = 1'b0;
                ph_comp[i] = 1'b0;
            end
`endif
            // While stopped, the shadows take the inputs this cycle, so the idle
            // level uses the incoming polarity.
            pol[i] = cen_i ? cfg_q[i][1] : cfg_in[i][1];
            if (!cen_i) begin
                ph_main[i] = 1'b0;
                ph_comp[i] = 1'b0;
            end
            pwm_d[i]  = ph_main[i] ^ pol[i];
            pwmn_d[i] = ph_comp[i] ^ pol[i];
        end
    end

    always_ff @(posedge clk_psc_i) begin
        // NOTE: state updates use non-blocking assignments so every flop samples
        // pre-edge values, whatever the statement order.
        if (rst_i) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
            update_q  <= 1'b0;
            psc_q     <= '0;
            arr_q     <= '1;
            pwm_q     <= '0;
            pwmn_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cfg_q[i]   <= '0;
            end
`ifdef PWM_DEADTIME_EN
            ref_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                dtg_q[i] <= 8'd1;
                dt_q[i]  <= '0;
            end
`endif
        end else begin
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
            update_q  <= update_d;
            psc_q     <= psc_d;
            arr_q     <= arr_d;
            pwm_q     <= pwm_d;
            pwmn_q    <= pwmn_d;
            for (int i = 0; i < 2; i++) begin
                start_q[i] <= start_d[i];
                end_q[i]   <= end_d[i];
                cfg_q[i]   <= cfg_d[i];
            end
`ifdef PWM_DEADTIME_EN
            ref_prev_q <= ref_prev_d;
            for (int i = 0; i < 2; i++) begin
                dtg_q[i] <= dtg_d[i];
                dt_q[i]  <= dt_d[i];
            end
`endif
        end
    end

    assign cnt_o      = cnt_q;
    assign update_o   = update_q;
    assign pwm_ch1_o  = pwm_q[0];
    assign pwm_ch1n_o = pwmn_q[0];
    assign pwm_ch2_o  = pwm_q[1];
    assign pwm_ch2n_o = pwmn_q[1];

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core -- scoreboard bench for pwm_core. The stimulus pushes
// cycle-tagged expected values into a queue. A monitor running on the falling
// edge pops every entry due in the current cycle and compares it with the DUT.

module tb_pwm_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, cen;
    logic [W-1:0] psc_pre, arr_pre;
    logic [W-1:0] s1, e1, s2, e2;
    logic [7:0]   cfg1, cfg2, dtg1, dtg2;
    logic         p1, p1n, p2, p2n, upd;
    logic [W-1:0] cnt;

    always #5 clk = ~clk;

    pwm_core #(.WIDTH(W)) dut (
        .clk_psc_i       (clk),
        .rst_i           (rst),
        .cen_i           (cen),
        .psc_preload_i   (psc_pre),
        .arr_preload_i   (arr_pre),
        .cmp_ch1_start_i (s1),
        .cmp_ch1_end_i   (e1),
        .cmp_ch2_start_i (s2),
        .cmp_ch2_end_i   (e2),
        .cfg_ch1_i       (cfg1),
        .cfg_ch2_i       (cfg2),
        .dtg_ch1_i       (dtg1),
        .dtg_ch2_i       (dtg2),
        .pwm_ch1_o       (p1),
        .pwm_ch1n_o      (p1n),
        .pwm_ch2_o       (p2),
        .pwm_ch2n_o      (p2n),
        .cnt_o           (cnt),
        .update_o        (upd)
    );

    typedef enum int {S_CNT, S_UPD, S_P1, S_P1N, S_P2, S_P2N} sig_e;
    typedef struct {
        int           cyc;
        sig_e         sig;
        logic [W-1:0] val;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t ent;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] actual(sig_e s);
        case (s)
            S_CNT:   return cnt;
            S_UPD:   return {{(W-1){1'b0}}, upd};
            S_P1:    return {{(W-1){1'b0}}, p1};
            S_P1N:   return {{(W-1){1'b0}}, p1n};
            S_P2:    return {{(W-1){1'b0}}, p2};
            default: return {{(W-1){1'b0}}, p2n};
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every expectation due in this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            ent = sb.pop_front();
            if (ent.cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: missed at cycle %0d, scheduled %0d", ent.name, cyc, ent.cyc);
            end else begin
                check(ent.name, actual(ent.sig), ent.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_at(input int c, input sig_e s, input logic [W-1:0] v, input string name);
        sb.push_back('{c, s, v, name});
    endtask

    // Stop the counter for one cycle so the shadows take the new settings.
    // Channel 2 has an empty window (7..3) with complementary output enabled.
    task automatic setup(input logic [W-1:0] psc, input logic [W-1:0] arr,
                         input logic [7:0] c1, input logic [7:0] d1);
        cen     = 1'b0;
        psc_pre = psc;
        arr_pre = arr;
        s1      = 16'd2;
        e1      = 16'd6;
        cfg1    = c1;
        dtg1    = d1;
        s2      = 16'd7;
        e2      = 16'd3;
        cfg2    = 8'h05;
        dtg2    = 8'd0;
        step(1);
    endtask

    // Run with arr=9, ch1 window 2..6, and check every cycle from the closed form.
    // The tick period is p=psc+1. At sample s+k, cnt=(k/p)%10, and the outputs
    // reflect the count one sample earlier.
    task automatic run_wave(input logic [W-1:0] psc, input logic [7:0] c1,
                            input logic [7:0] d1, input int ncyc, input string name);
        int s, p, cc, cp;
        logic inr, en, pl, cm, x1, x1n;
        setup(psc, 16'd9, c1, d1);
        s   = cyc;
        cen = 1'b1;
        p   = int'(psc) + 1;
        en  = c1[0];
        pl  = c1[1];
        cm  = c1[2];
        for (int k = 1; k <= ncyc; k++) begin
            cc  = (k / p) % 10;
            cp  = ((k - 1) / p) % 10;
            inr = (cp >= 2) && (cp < 6);
            x1  = en ? (inr ^ pl) : pl;
            x1n = ((en && cm) ? !inr : 1'b0) ^ pl;
`ifdef PWM_DEADTIME_EN
            if (d1 != 8'd0) begin
                // D=3: the rise at count 2 shows after count 5; the rise at 6 shows after 9.
                x1  = (cp == 5);
                x1n = (cp == 9) || (cp <= 1);
            end
`endif
            exp_at(s + k, S_CNT, W'(cc), $sformatf("%s cnt k=%0d", name, k));
            exp_at(s + k, S_UPD, W'((k % (10 * p)) == 0), $sformatf("%s update k=%0d", name, k));
            exp_at(s + k, S_P1,  W'(x1),  $sformatf("%s ch1 k=%0d", name, k));
            exp_at(s + k, S_P1N, W'(x1n), $sformatf("%s ch1n k=%0d", name, k));
            exp_at(s + k, S_P2,  W'(0), $sformatf("%s ch2 empty k=%0d", name, k));
            exp_at(s + k, S_P2N, W'(1), $sformatf("%s ch2n empty k=%0d", name, k));
        end
        step(ncyc);
    endtask

    initial begin
        int s;
        rst     = 1'b1;
        cen     = 1'b1;
        psc_pre = '0;
        arr_pre = 16'd9;
        s1 = 16'd2; e1 = 16'd6; s2 = 16'd7; e2 = 16'd3;
        cfg1 = 8'h01; cfg2 = 8'h05; dtg1 = 8'd0; dtg2 = 8'd0;

        // Reset wins over cen_i.
        exp_at(1, S_CNT, '0, "reset cnt");
        exp_at(1, S_UPD, '0, "reset update");
        exp_at(1, S_P1,  '0, "reset ch1");
        exp_at(1, S_P1N, '0, "reset ch1n");
        exp_at(1, S_P2,  '0, "reset ch2");
        exp_at(1, S_P2N, '0, "reset ch2n");
        step(1);
        rst = 1'b0;
        cen = 1'b0;
        step(1);

        run_wave(16'd0, 8'h01, 8'd0, 30, "psc0");
        run_wave(16'd1, 8'h01, 8'd0, 40, "psc1");
        run_wave(16'd0, 8'h03, 8'd0, 20, "inverted");
        run_wave(16'd0, 8'h02, 8'd0, 20, "disabled");
        run_wave(16'd0, 8'h05, 8'd3, 30, "complementary");

        // Shrinking arr mid-period: the current period still reaches 9.
        setup(16'd0, 16'd9, 8'h01, 8'd0);
        s   = cyc;
        cen = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            exp_at(s + k, S_CNT, W'((k < 10) ? k : (k - 10) % 5), $sformatf("arr change cnt k=%0d", k));
            exp_at(s + k, S_UPD, W'((k == 10) || (k == 15) || (k == 20)), $sformatf("arr change update k=%0d", k));
        end
        step(3);
        arr_pre = 16'd4;
        step(21);

        // Dropping cen_i mid-period stops everything at the next edge.
        setup(16'd0, 16'd9, 8'h01, 8'd0);
        s   = cyc;
        cen = 1'b1;
        exp_at(s + 4, S_CNT, 16'd4, "cen drop before cnt");
        exp_at(s + 4, S_P1,  16'd1, "cen drop before ch1");
        step(4);
        cen = 1'b0;
        exp_at(s + 5, S_CNT, 16'd0, "cen drop cnt");
        exp_at(s + 5, S_P1,  16'd0, "cen drop ch1");
        exp_at(s + 5, S_UPD, 16'd0, "cen drop update");
        exp_at(s + 6, S_CNT, 16'd0, "cen drop cnt hold");
        step(2);

        // arr=0: the count stays at 0 and every tick wraps.
        setup(16'd0, 16'd0, 8'h01, 8'd0);
        s   = cyc;
        cen = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            exp_at(s + k, S_CNT, 16'd0, $sformatf("arr0 cnt k=%0d", k));
            exp_at(s + k, S_UPD, 16'd1, $sformatf("arr0 update k=%0d", k));
        end
        step(5);

        // One-cycle reset at cnt=5 while cen_i stays high.
        setup(16'd0, 16'd9, 8'h01, 8'd0);
        s   = cyc;
        cen = 1'b1;
        exp_at(s + 5, S_CNT, 16'd5, "midreset before cnt");
        exp_at(s + 5, S_P2N, 16'd1, "midreset before ch2n");
        exp_at(s + 6, S_CNT, 16'd0, "midreset cnt");
        exp_at(s + 6, S_UPD, 16'd0, "midreset update");
        exp_at(s + 6, S_P1,  16'd0, "midreset ch1");
        exp_at(s + 6, S_P1N, 16'd0, "midreset ch1n");
        exp_at(s + 6, S_P2,  16'd0, "midreset ch2");
        exp_at(s + 6, S_P2N, 16'd0, "midreset ch2n");
        for (int k = 1; k <= 12; k++) begin
            exp_at(s + 6 + k, S_CNT, W'(k), $sformatf("post reset cnt k=%0d", k));
            exp_at(s + 6 + k, S_P1,  16'd0, $sformatf("post reset ch1 k=%0d", k));
            exp_at(s + 6 + k, S_UPD, 16'd0, $sformatf("post reset update k=%0d", k));
        end
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(12);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: actual %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
